rv32_mod_instruction_prefetch: RTL and testbench

//  Parametrised prefetching instruction fetch unit for the rv32imc cores; next generation of
//  rv32_mod_instruction_fetch. Fetches aligned 32-bit words ahead of execution into a DEPTH-entry

---
 rtl/rv32_mod_instruction_prefetch.sv | 198 +++++++++++++++++++
 tb/tb_rv32_mod_instruction_prefetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mod_instruction_prefetch.sv
// Prefetching instruction fetch unit: keeps a DEPTH-word buffer ahead of execution and
// extracts 16/32-bit instructions at halfword PCs, including words that straddle.
module rv32_mod_instruction_prefetch #(
   parameter logic [31:0] INITIAL_PC = 32'h1000_0000,
   parameter int          DEPTH      = 2,
   parameter bit          ENABLE_C   = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_addr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        out_is_compressed,
   output logic        out_err,
   output logic        instr_req,
   input  logic        instr_ack,
   input  logic        instr_err,
   output logic [31:0] instr_addr,
   input  logic [31:0] instr_data_i
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   // Without RVC every PC is word aligned, so bit 1 is dropped along with bit 0.
   localparam logic [31:0] PC_MASK = ENABLE_C ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

   state_t            state_reg;
   logic [31:0]       pc_reg;
   logic [31:0]       fetch_addr_reg;
   logic              halted_reg;
   logic              err_stop_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  count_next;
   logic [32:0]       entry_mem [DEPTH];

   logic [32:0] head_word;
   logic [32:0] next_word;
   logic        have_h, have_n;
   logic        ex_valid, ex_err, ex_comp;
   logic [31:0] ex_instr;
   logic        rsp, push, pop, xfer, room;
   logic [31:0] redirect_word;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign head_word     = entry_mem[rd_ptr_reg];
   assign next_word     = entry_mem[ptr_inc(rd_ptr_reg)];
   assign have_h        = (count_reg != '0);
   assign have_n        = (count_reg >= CNT_W'(2));
   assign redirect_word = redirect_addr & 32'hFFFF_FFFC;

   always_comb begin
      ex_comp  = 1'b0;
      ex_instr = head_word[31:0];
      ex_valid = have_h;
      ex_err   = head_word[32];
      if (ENABLE_C) begin
         if (!pc_reg[1]) begin
            ex_comp = (head_word[1:0] != 2'b11);
            if (ex_comp) ex_instr = {16'h0, head_word[15:0]};
         end else begin
            ex_comp = (head_word[17:16] != 2'b11);
            if (ex_comp) begin
               ex_instr = {16'h0, head_word[31:16]};
            end else begin
               // Straddling word: a faulted head is reported without waiting for N.
               ex_instr = {next_word[15:0], head_word[31:16]};
               ex_valid = have_h && (head_word[32] || have_n);
               ex_err   = head_word[32] || (have_n && next_word[32]);
            end
         end
      end
   end

   assign out_valid         = ex_valid && !err_stop_reg;
   assign out_instr         = out_valid ? ex_instr : 32'h0;
   assign out_is_compressed = out_valid && ex_comp;
   assign out_err           = out_valid && ex_err;
   assign out_pc            = pc_reg;

   assign rsp  = instr_ack || instr_err;
   assign xfer = out_valid && out_ready && !redirect_valid;
   assign pop  = xfer && (pc_reg[1] || !ex_comp);
   assign push = (state_reg == S_REQ) && rsp && !redirect_valid;

   always_comb begin
      count_next = count_reg;
      if (redirect_valid)     count_next = '0;
      else if (push && !pop)  count_next = count_reg + CNT_W'(1);
      else if (pop && !push)  count_next = count_reg - CNT_W'(1);
   end
   assign room = (count_next < DEPTH_C);

   always_ff @(posedge clk) begin
      if (push) entry_mem[wr_ptr_reg] <= {instr_err, instr_data_i};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_reg       <= INITIAL_PC & PC_MASK;
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         err_stop_reg <= 1'b0;
      end else begin
         count_reg <= count_next;
         if (redirect_valid) begin
            pc_reg       <= redirect_addr & PC_MASK;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            err_stop_reg <= 1'b0;
         end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (xfer) begin
               pc_reg <= pc_reg + (ex_comp ? 32'd2 : 32'd4);
               if (ex_err) err_stop_reg <= 1'b1;
            end
         end
      end
   end

   // Bus side: a started transfer always completes; DRAIN swallows a response made stale by a redirect.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= S_IDLE;
         instr_req      <= 1'b0;
         instr_addr     <= 32'h0;
         fetch_addr_reg <= INITIAL_PC & 32'hFFFF_FFFC;
         halted_reg     <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (redirect_valid) begin
                  fetch_addr_reg <= redirect_word;
                  halted_reg     <= 1'b0;
               end else if (!halted_reg && room) begin
                  state_reg  <= S_REQ;
                  instr_req  <= 1'b1;
                  instr_addr <= fetch_addr_reg;
               end
            end
            S_REQ: begin
               if (rsp) begin
                  if (redirect_valid) begin
                     fetch_addr_reg <= redirect_word;
                     halted_reg     <= 1'b0;
                     state_reg      <= S_IDLE;
                     instr_req      <= 1'b0;
                  end else if (instr_err) begin
                     halted_reg <= 1'b1;
                     state_reg  <= S_IDLE;
                     instr_req  <= 1'b0;
                  end else begin
                     fetch_addr_reg <= fetch_addr_reg + 32'd4;
                     if (room) begin
                        instr_addr <= fetch_addr_reg + 32'd4;
                     end else begin
                        state_reg <= S_IDLE;
                        instr_req <= 1'b0;
                     end
                  end
               end else if (redirect_valid) begin
                  fetch_addr_reg <= redirect_word;
                  halted_reg     <= 1'b0;
                  state_reg      <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (redirect_valid) begin
                  fetch_addr_reg <= redirect_word;
                  halted_reg     <= 1'b0;
                  if (rsp) begin
                     state_reg <= S_IDLE;
                     instr_req <= 1'b0;
                  end
               end else if (rsp) begin
                  state_reg  <= S_REQ;
                  instr_addr <= fetch_addr_reg;
               end
            end
            default: begin
               state_reg <= S_IDLE;
               instr_req <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rv32_mod_instruction_prefetch.sv
// Directed bench for the prefetch unit: an RVC/DEPTH=2 instance and a word-only/DEPTH=4
// instance, each fed by a small bus responder over a fixed instruction memory.
module tb_rv32_mod_instruction_prefetch;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        out_valid, out_ready, out_is_compressed, out_err;
   logic [31:0] out_instr, out_pc;
   logic        instr_req;
   logic        instr_ack = 1'b0;
   logic        instr_err = 1'b0;
   logic [31:0] instr_addr;
   logic [31:0] instr_data_i = 32'h0;

   logic        n_redirect_valid;
   logic [31:0] n_redirect_addr;
   logic        n_out_valid, n_out_ready, n_out_is_compressed, n_out_err;
   logic [31:0] n_out_instr, n_out_pc;
   logic        n_instr_req;
   logic        n_instr_ack = 1'b0;
   logic        n_instr_err = 1'b0;
   logic [31:0] n_instr_addr;
   logic [31:0] n_instr_data_i = 32'h0;

   int checks = 0;
   int errors = 0;
   int ack_lat = 0;
   int wait_cnt = 0;
   int ack_count = 0;
   logic [31:0] bad_addr = 32'hFFFF_FFF0;
   logic found;

   rv32_mod_instruction_prefetch u_dut (
      .clk(clk), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .out_is_compressed(out_is_compressed), .out_err(out_err),
      .instr_req(instr_req), .instr_ack(instr_ack), .instr_err(instr_err),
      .instr_addr(instr_addr), .instr_data_i(instr_data_i)
   );

   rv32_mod_instruction_prefetch #(.DEPTH(4), .ENABLE_C(1'b0)) u_dut_nc (
      .clk(clk), .reset(reset),
      .redirect_valid(n_redirect_valid), .redirect_addr(n_redirect_addr),
      .out_valid(n_out_valid), .out_ready(n_out_ready), .out_instr(n_out_instr), .out_pc(n_out_pc),
      .out_is_compressed(n_out_is_compressed), .out_err(n_out_err),
      .instr_req(n_instr_req), .instr_ack(n_instr_ack), .instr_err(n_instr_err),
      .instr_addr(n_instr_addr), .instr_data_i(n_instr_data_i)
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      case (a)
         32'h1000_0000: mem = 32'h0000_0013;
         32'h2000_0000: mem = 32'h4505_0000;
         32'h2000_0004: mem = 32'h0000_0013;
         32'h4000_0000: mem = 32'h0013_4501;
         32'h4000_0004: mem = 32'h0000_0013;
         32'h4000_0008: mem = 32'h0000_0013;
         32'h3000_0010: mem = 32'h0013_4501;
         default:       mem = {a[31:2], 2'b11};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
      end else begin
         $display("ok   %s = %08h", tag, got);
      end
   endtask

   // Responder for the RVC instance: answers after ack_lat waiting cycles, errors on bad_addr.
   always @(posedge clk) begin
      #2;
      instr_ack = 1'b0;
      instr_err = 1'b0;
      if (instr_req) begin
         if (wait_cnt >= ack_lat) begin
            wait_cnt = 0;
            if (instr_addr == bad_addr) begin
               instr_err    = 1'b1;
               instr_data_i = 32'hDEAD_BEEF;
            end else begin
               instr_ack    = 1'b1;
               instr_data_i = mem(instr_addr);
               ack_count++;
            end
         end else begin
            wait_cnt++;
         end
      end
   end

   always @(posedge clk) begin
      #2;
      n_instr_ack    = n_instr_req;
      n_instr_data_i = mem(n_instr_addr);
   end

   initial begin
      reset = 1'b0;
      redirect_valid = 1'b0; redirect_addr = 32'h0; out_ready = 1'b0;
      n_redirect_valid = 1'b0; n_redirect_addr = 32'h0; n_out_ready = 1'b1;
      found = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_instr_req", 32'(instr_req), 32'h0);
      check("rst_instr_addr", instr_addr, 32'h0);
      check("rst_out_pc", out_pc, 32'h1000_0000);
      check("rst_out_instr", out_instr, 32'h0);
      check("rst_nc_out_pc", n_out_pc, 32'h1000_0000);
      reset = 1'b1;

      // first fetch, ack in the request cycle
      @(negedge clk);
      check("t1_req", 32'(instr_req), 32'h1);
      check("t1_addr", instr_addr, 32'h1000_0000);
      check("t1_no_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
      check("t1_valid", 32'(out_valid), 32'h1);
      check("t1_instr", out_instr, 32'h0000_0013);
      check("t1_pc", out_pc, 32'h1000_0000);
      check("t1_comp", 32'(out_is_compressed), 32'h0);
      out_ready = 1'b1;
      @(negedge clk);
      check("t1_pc2", out_pc, 32'h1000_0004);
      check("t1_instr2", out_instr, 32'h1000_0007);
      out_ready = 1'b0;

      // consumer stalls: buffer fills to DEPTH and the bus goes quiet
      repeat (10) @(negedge clk);
      check("t3_req_low", 32'(instr_req), 32'h0);
      check("t3_acks", 32'(ack_count), 32'd3);
      check("t3_pc_hold", out_pc, 32'h1000_0004);
      check("t3_instr_hold", out_instr, 32'h1000_0007);
      out_ready = 1'b1;
      ack_lat = 3;
      @(negedge clk);
      check("t3_refill_req", 32'(instr_req), 32'h1);
      check("t3_refill_addr", instr_addr, 32'h1000_000C);
      check("t3_pc", out_pc, 32'h1000_0008);

      // redirect while that request waits for its slow ack
      redirect_valid = 1'b1; redirect_addr = 32'h2000_0002;
      @(negedge clk);
      redirect_valid = 1'b0;
      check("t4_flush", 32'(out_valid), 32'h0);
      check("t4_addr_held", instr_addr, 32'h1000_000C);
      check("t4_req_held", 32'(instr_req), 32'h1);
      check("t4_new_pc", out_pc, 32'h2000_0002);
      @(negedge clk);
      check("t4_addr_held2", instr_addr, 32'h1000_000C);
      @(negedge clk);
      check("t4_late_ack", 32'(instr_ack), 32'h1);
      ack_lat = 0;
      @(negedge clk);
      check("t4_new_req", instr_addr, 32'h2000_0000);
      check("t4_dropped", 32'(out_valid), 32'h0);
      @(negedge clk);
      check("t4_valid", 32'(out_valid), 32'h1);
      check("t4_pc", out_pc, 32'h2000_0002);
      check("t4_instr", out_instr, 32'h0000_4505);
      check("t4_comp", 32'(out_is_compressed), 32'h1);
      @(negedge clk);
      check("t4_pc2", out_pc, 32'h2000_0004);
      check("t4_instr2", out_instr, 32'h0000_0013);

      // compressed then straddling 32-bit instruction
      redirect_valid = 1'b1; redirect_addr = 32'h4000_0000;
      @(negedge clk);
      redirect_valid = 1'b0;
      check("t2_flush", 32'(out_valid), 32'h0);
      check("t2_ack_dropped_idle", 32'(instr_req), 32'h0);
      @(negedge clk);
      check("t2_req_addr", instr_addr, 32'h4000_0000);
      @(negedge clk);
      check("t2_c_instr", out_instr, 32'h0000_4501);
      check("t2_c_flag", 32'(out_is_compressed), 32'h1);
      check("t2_c_pc", out_pc, 32'h4000_0000);
      @(negedge clk);
      check("t2_s_pc", out_pc, 32'h4000_0002);
      check("t2_s_instr", out_instr, 32'h0013_0013);
      check("t2_s_comp", 32'(out_is_compressed), 32'h0);
      @(negedge clk);
      check("t2_pc6", out_pc, 32'h4000_0006);
      check("t2_pc6_comp", 32'(out_is_compressed), 32'h1);

      // bus error on the second word
      redirect_valid = 1'b1; redirect_addr = 32'h5000_0000; bad_addr = 32'h5000_0004;
      @(negedge clk);
      redirect_valid = 1'b0;
      check("t5_flush", 32'(out_valid), 32'h0);
      repeat (2) @(negedge clk);
      check("t5_first", out_instr, 32'h5000_0003);
      check("t5_first_err", 32'(out_err), 32'h0);
      @(negedge clk);
      check("t5_err_valid", 32'(out_valid), 32'h1);
      check("t5_err", 32'(out_err), 32'h1);
      check("t5_err_pc", out_pc, 32'h5000_0004);
      @(negedge clk);
      check("t5_stopped", 32'(out_valid), 32'h0);
      repeat (3) @(negedge clk);
      check("t5_halted", 32'(instr_req), 32'h0);
      redirect_valid = 1'b1; redirect_addr = 32'h6000_0000;
      @(negedge clk);
      redirect_valid = 1'b0;
      @(negedge clk);
      check("t5_resume_addr", instr_addr, 32'h6000_0000);
      check("t5_resume_req", 32'(instr_req), 32'h1);
      @(negedge clk);
      check("t5_resume_pc", out_pc, 32'h6000_0000);
      check("t5_resume_err", 32'(out_err), 32'h0);

      // word-only instance, DEPTH=4, halfword bit of the redirect ignored
      n_redirect_valid = 1'b1; n_redirect_addr = 32'h3000_000E;
      @(negedge clk);
      n_redirect_valid = 1'b0;
      check("t6_flush", 32'(n_out_valid), 32'h0);
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (n_out_valid) found = 1'b1;
      end
      check("t6_found", 32'(found), 32'h1);
      check("t6_pc", n_out_pc, 32'h3000_000C);
      check("t6_instr", n_out_instr, 32'h3000_000F);
      check("t6_comp", 32'(n_out_is_compressed), 32'h0);
      check("t6_next_req", n_instr_addr, 32'h3000_0010);
      @(negedge clk);
      check("t6_pc2", n_out_pc, 32'h3000_0010);
      check("t6_instr2", n_out_instr, 32'h0013_4501);
      check("t6_comp2", 32'(n_out_is_compressed), 32'h0);
      @(negedge clk);
      check("t6_pc3", n_out_pc, 32'h3000_0014);
      check("t6_instr3", n_out_instr, 32'h3000_0017);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
      $finish;
   end
endmodule
